// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: default datapath widths used by rename,
// reorder_buffer, reg_file and commit_scheduler, plus the commit FSM state type.
package ooo_pkg;

  localparam int unsigned PREG_W_DEF = 6;
  localparam int unsigned AREG_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  // Commit scheduler state encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] sched_state_t;
  localparam sched_state_t IDLE  = 2'd0;
  localparam sched_state_t RUN   = 2'd1;
  localparam sched_state_t FLUSH = 2'd2;

  // Number of slots retired in one cycle (0, 1 or 2).
  function automatic logic [1:0] slot_count(input logic acc1, input logic acc2);
    return {1'b0, acc1} + {1'b0, acc2};
  endfunction

endpackage

// File: rtl/commit_scheduler_if.sv
// ROB-to-retire bundle of the commit scheduler: dual commit slots from the ROB,
// free-list release strobes, regfile write ports and status.
// master = ROB/pipeline side, slave = commit_scheduler.
interface commit_scheduler_if #(
  parameter int unsigned PREG_W = ooo_pkg::PREG_W_DEF,
  parameter int unsigned AREG_W = ooo_pkg::AREG_W_DEF,
  parameter int unsigned DATA_W = ooo_pkg::DATA_W_DEF
);

  logic              flush;
  logic              hold;

  logic              rob_commit_valid_1;
  logic              rob_commit_valid_2;
  logic [PREG_W-1:0] rob_commit_dest_1;
  logic [PREG_W-1:0] rob_commit_dest_2;
  logic [PREG_W-1:0] rob_free_oldDest_1;
  logic [PREG_W-1:0] rob_free_oldDest_2;
  logic [AREG_W-1:0] rob_commit_arch_1;
  logic [AREG_W-1:0] rob_commit_arch_2;
  logic [DATA_W-1:0] rob_commit_value_1;
  logic [DATA_W-1:0] rob_commit_value_2;
  logic              rob_commit_ready;

  logic              retire_valid1;
  logic              retire_valid2;
  logic [PREG_W-1:0] retire_phys_reg1;
  logic [PREG_W-1:0] retire_phys_reg2;
  logic [PREG_W-1:0] retire_cur_phys_reg1;
  logic [PREG_W-1:0] retire_cur_phys_reg2;

  logic              RegWrite1;
  logic              RegWrite2;
  logic [AREG_W-1:0] rd1;
  logic [AREG_W-1:0] rd2;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;

  logic [31:0]       commit_count;
  logic              busy;

  modport master (
    output flush, hold,
    output rob_commit_valid_1, rob_commit_valid_2,
    output rob_commit_dest_1, rob_commit_dest_2,
    output rob_free_oldDest_1, rob_free_oldDest_2,
    output rob_commit_arch_1, rob_commit_arch_2,
    output rob_commit_value_1, rob_commit_value_2,
    input  rob_commit_ready,
    input  retire_valid1, retire_valid2,
    input  retire_phys_reg1, retire_phys_reg2,
    input  retire_cur_phys_reg1, retire_cur_phys_reg2,
    input  RegWrite1, RegWrite2, rd1, rd2, rd1_data, rd2_data,
    input  commit_count, busy
  );

  modport slave (
    input  flush, hold,
    input  rob_commit_valid_1, rob_commit_valid_2,
    input  rob_commit_dest_1, rob_commit_dest_2,
    input  rob_free_oldDest_1, rob_free_oldDest_2,
    input  rob_commit_arch_1, rob_commit_arch_2,
    input  rob_commit_value_1, rob_commit_value_2,
    output rob_commit_ready,
    output retire_valid1, retire_valid2,
    output retire_phys_reg1, retire_phys_reg2,
    output retire_cur_phys_reg1, retire_cur_phys_reg2,
    output RegWrite1, RegWrite2, rd1, rd2, rd1_data, rd2_data,
    output commit_count, busy
  );

endinterface

// File: rtl/commit_perf_ctr.sv
// Retired-instruction counter: adds 0/1/2 per cycle, wraps mod 2^32,
// synchronous active-high reset. Only built with COMMIT_PERF_EN.
module commit_perf_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  inc,
  output logic [31:0] count
);

  // Accumulate retired slots; flush has no effect here.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count + 32'(inc);
    end
  end

endmodule

// File: rtl/commit_scheduler.sv
// Commit scheduler: accepts up to two in-order commits per cycle from the ROB,
// registers them and presents free-list release and regfile write ports one
// cycle later. A flush opens a FLUSH_CYCLES blackout on new commits.
// Optional feature: define COMMIT_PERF_EN to build the commit_count counter;
// otherwise commit_count is tied to 0.
module commit_scheduler
  import ooo_pkg::*;
#(
  parameter int unsigned PREG_W       = PREG_W_DEF,
  parameter int unsigned AREG_W       = AREG_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  commit_scheduler_if.slave bus
);

  localparam int unsigned CntW = $clog2(FLUSH_CYCLES + 1) + 1;

  sched_state_t      state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              out_en;
  logic              ready;
  logic              acc1, acc2;
  logic              we1_d, we2_d;

  logic              v1_q, v2_q;
  logic              we1_q, we2_q;
  logic [PREG_W-1:0] old1_q, old2_q;
  logic [PREG_W-1:0] cur1_q, cur2_q;
  logic [AREG_W-1:0] rd1_q, rd2_q;
  logic [DATA_W-1:0] data1_q, data2_q;

  // Reset masks every output combinationally so an in-flight retire never
  // leaks out while reset is held.
  assign out_en = ~reset;

  assign ready = out_en & (state_q == RUN) & ~bus.hold & ~bus.flush;
  assign bus.rob_commit_ready = ready;

  // Slot 2 only retires behind slot 1 to keep commits in program order.
  assign acc1 = ready & bus.rob_commit_valid_1;
  assign acc2 = acc1 & bus.rob_commit_valid_2;

  // x0 is never written; on a same-rd pair the younger slot owns the write.
  assign we2_d = acc2 & (bus.rob_commit_arch_2 != '0);
  assign we1_d = acc1 & (bus.rob_commit_arch_1 != '0) &
                 ~(acc2 & (bus.rob_commit_arch_1 == bus.rob_commit_arch_2));

  // Next-state logic: IDLE -> RUN, flush blackout countdown in FLUSH.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.flush) begin
          state_d = FLUSH;
          cnt_d   = CntW'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (bus.flush) begin
          cnt_d = CntW'(FLUSH_CYCLES);
        end else if (cnt_q <= CntW'(1)) begin
          // Last blackout cycle: resume commits on the following cycle.
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and blackout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Retire pipeline register; payload is zeroed for slots not accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      we1_q   <= 1'b0;
      we2_q   <= 1'b0;
      old1_q  <= '0;
      old2_q  <= '0;
      cur1_q  <= '0;
      cur2_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      v1_q    <= acc1;
      v2_q    <= acc2;
      we1_q   <= we1_d;
      we2_q   <= we2_d;
      old1_q  <= acc1 ? bus.rob_free_oldDest_1 : '0;
      old2_q  <= acc2 ? bus.rob_free_oldDest_2 : '0;
      cur1_q  <= acc1 ? bus.rob_commit_dest_1  : '0;
      cur2_q  <= acc2 ? bus.rob_commit_dest_2  : '0;
      rd1_q   <= acc1 ? bus.rob_commit_arch_1  : '0;
      rd2_q   <= acc2 ? bus.rob_commit_arch_2  : '0;
      data1_q <= acc1 ? bus.rob_commit_value_1 : '0;
      data2_q <= acc2 ? bus.rob_commit_value_2 : '0;
    end
  end

  // Retire / regfile outputs and busy status, all masked by reset.
  always_comb begin
    bus.retire_valid1        = out_en & v1_q;
    bus.retire_valid2        = out_en & v2_q;
    bus.retire_phys_reg1     = out_en ? old1_q : '0;
    bus.retire_phys_reg2     = out_en ? old2_q : '0;
    bus.retire_cur_phys_reg1 = out_en ? cur1_q : '0;
    bus.retire_cur_phys_reg2 = out_en ? cur2_q : '0;
    bus.RegWrite1            = out_en & we1_q;
    bus.RegWrite2            = out_en & we2_q;
    bus.rd1                  = out_en ? rd1_q : '0;
    bus.rd2                  = out_en ? rd2_q : '0;
    bus.rd1_data             = out_en ? data1_q : '0;
    bus.rd2_data             = out_en ? data2_q : '0;
    bus.busy                 = out_en & ((state_q != RUN) | v1_q | v2_q);
  end

`ifdef COMMIT_PERF_EN
  logic [1:0]  perf_inc;
  logic [31:0] perf_count;

  assign perf_inc = slot_count(acc1, acc2);

  commit_perf_ctr u_commit_perf_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (perf_inc),
    .count (perf_count)
  );

  assign bus.commit_count = out_en ? perf_count : '0;
`else
  assign bus.commit_count = '0;
`endif

endmodule

// File: tb/tb_commit_scheduler.sv
// Self-checking bench for commit_scheduler: reset checks, a table of directed
// commit patterns, hand-written flush / reset sequences and randomized traffic
// compared against a cycle-number based reference model.
module tb_commit_scheduler;

  localparam int unsigned PW = 6;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned FC = 2;

  typedef struct packed {
    logic          v1, v2;
    logic [PW-1:0] dest1, dest2, old1, old2;
    logic [AW-1:0] arch1, arch2;
    logic [DW-1:0] val1, val2;
    logic          hold, flush;
  } stim_t;

  typedef struct packed {
    logic          rv1, rv2, we1, we2;
    logic [PW-1:0] rp1, rp2, rc1, rc2;
    logic [AW-1:0] rd1, rd2;
    logic [DW-1:0] d1, d2;
  } ret_t;

  typedef struct packed {
    stim_t s;
    ret_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  commit_scheduler_if #(.PREG_W(PW), .AREG_W(AW), .DATA_W(DW)) bus ();

  commit_scheduler #(
    .PREG_W       (PW),
    .AREG_W       (AW),
    .DATA_W       (DW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_pass;
  int          n_total;
  int          cyc;          // cycle index since reset release
  int          ready_from;   // first cycle commits may be accepted again
  int          idle_cyc;     // the single IDLE cycle after reset
  int unsigned model_count;
  ret_t        pend;         // outputs expected after the current cycle
  vec_t        vecs[7];

  function automatic stim_t mk_stim(input int unsigned v1, v2, dest1, dest2, old1, old2,
                                    arch1, arch2, val1, val2, hold, flush);
    stim_t s;
    s.v1 = v1[0];  s.v2 = v2[0];
    s.dest1 = PW'(dest1);  s.dest2 = PW'(dest2);
    s.old1 = PW'(old1);    s.old2 = PW'(old2);
    s.arch1 = AW'(arch1);  s.arch2 = AW'(arch2);
    s.val1 = val1;         s.val2 = val2;
    s.hold = hold[0];      s.flush = flush[0];
    return s;
  endfunction

  function automatic ret_t mk_ret(input int unsigned rv1, rv2, we1, we2, rp1, rp2, rc1, rc2,
                                  rd1, rd2, d1, d2);
    ret_t r;
    r.rv1 = rv1[0];  r.rv2 = rv2[0];  r.we1 = we1[0];  r.we2 = we2[0];
    r.rp1 = PW'(rp1);  r.rp2 = PW'(rp2);
    r.rc1 = PW'(rc1);  r.rc2 = PW'(rc2);
    r.rd1 = AW'(rd1);  r.rd2 = AW'(rd2);
    r.d1 = d1;  r.d2 = d2;
    return r;
  endfunction

  // Reference: what retires one cycle after inputs s are presented.
  function automatic ret_t model_retire(input stim_t s, input logic rdy);
    ret_t r;
    logic a1, a2;
    r  = '0;
    a1 = s.v1 & rdy;
    a2 = a1 & s.v2;
    if (a1) begin
      r.rv1 = 1'b1;  r.rp1 = s.old1;  r.rc1 = s.dest1;  r.rd1 = s.arch1;  r.d1 = s.val1;
      r.we1 = (s.arch1 != 0) && !(a2 && (s.arch1 == s.arch2));
    end
    if (a2) begin
      r.rv2 = 1'b1;  r.rp2 = s.old2;  r.rc2 = s.dest2;  r.rd2 = s.arch2;  r.d2 = s.val2;
      r.we2 = (s.arch2 != 0);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_ret(input string tag, input ret_t e);
    check({tag, ".retire_valid1"},        64'(bus.retire_valid1),        64'(e.rv1));
    check({tag, ".retire_valid2"},        64'(bus.retire_valid2),        64'(e.rv2));
    check({tag, ".RegWrite1"},            64'(bus.RegWrite1),            64'(e.we1));
    check({tag, ".RegWrite2"},            64'(bus.RegWrite2),            64'(e.we2));
    check({tag, ".retire_phys_reg1"},     64'(bus.retire_phys_reg1),     64'(e.rp1));
    check({tag, ".retire_phys_reg2"},     64'(bus.retire_phys_reg2),     64'(e.rp2));
    check({tag, ".retire_cur_phys_reg1"}, 64'(bus.retire_cur_phys_reg1), 64'(e.rc1));
    check({tag, ".retire_cur_phys_reg2"}, 64'(bus.retire_cur_phys_reg2), 64'(e.rc2));
    check({tag, ".rd1"},                  64'(bus.rd1),                  64'(e.rd1));
    check({tag, ".rd2"},                  64'(bus.rd2),                  64'(e.rd2));
    check({tag, ".rd1_data"},             64'(bus.rd1_data),             64'(e.d1));
    check({tag, ".rd2_data"},             64'(bus.rd2_data),             64'(e.d2));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rob_commit_ready"}, 64'(bus.rob_commit_ready), 64'(0));
    check({tag, ".busy"},             64'(bus.busy),             64'(0));
    check({tag, ".commit_count"},     64'(bus.commit_count),     64'(0));
    check_ret(tag, '0);
  endtask

  task automatic apply(input stim_t s);
    bus.rob_commit_valid_1 = s.v1;     bus.rob_commit_valid_2 = s.v2;
    bus.rob_commit_dest_1  = s.dest1;  bus.rob_commit_dest_2  = s.dest2;
    bus.rob_free_oldDest_1 = s.old1;   bus.rob_free_oldDest_2 = s.old2;
    bus.rob_commit_arch_1  = s.arch1;  bus.rob_commit_arch_2  = s.arch2;
    bus.rob_commit_value_1 = s.val1;   bus.rob_commit_value_2 = s.val2;
    bus.hold  = s.hold;
    bus.flush = s.flush;
  endtask

  // One clock of stimulus starting at a negedge; exp_rdy >= 0 adds a fixed
  // expectation for rob_commit_ready on top of the model.
  task automatic run_cycle(input stim_t s, input int exp_rdy);
    logic rdy_m;
    logic busy_m;
    apply(s);
    #1;
    rdy_m = (cyc >= ready_from) && !s.hold && !s.flush;
    check("rob_commit_ready", 64'(bus.rob_commit_ready), 64'(rdy_m));
    if (exp_rdy >= 0) check("ready_fixed", 64'(bus.rob_commit_ready), 64'(exp_rdy));
    pend = model_retire(s, rdy_m);
    model_count = model_count + 32'(pend.rv1) + 32'(pend.rv2);
    if (s.flush && cyc != idle_cyc) ready_from = cyc + FC + 1;
    @(negedge clk);
    cyc++;
    check_ret("retire", pend);
    busy_m = (cyc < ready_from) || pend.rv1;
    check("busy", 64'(bus.busy), 64'(busy_m));
`ifdef COMMIT_PERF_EN
    check("commit_count", 64'(bus.commit_count), 64'(model_count));
`else
    check("commit_count", 64'(bus.commit_count), 64'(0));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(mk_stim(1, 1, 3, 4, 5, 6, 7, 8, 9, 10, 0, 0));
    #1;
    check_zero("reset_held");
    @(negedge clk);
    #1;
    check_zero("reset_edge");
    @(negedge clk);
    reset = 1'b0;
    apply('0);
    cyc = 0;
    ready_from = 1;
    idle_cyc = 0;
    model_count = 0;
    pend = '0;
  endtask

  stim_t s_dual, s_single, s_idle, s_valid, s_flush, s_flush_v;

  initial begin
    n_pass = 0;
    n_total = 0;
    s_dual    = mk_stim(1, 1, 32, 33, 1, 2, 1, 2, 32'hAABBCCDD, 32'h11223344, 0, 0);
    s_single  = mk_stim(1, 0, 20, 0, 9, 0, 4, 0, 32'h0000BEEF, 0, 0, 0);
    s_idle    = '0;
    s_valid   = mk_stim(1, 1, 12, 13, 14, 15, 6, 7, 32'h55, 32'h66, 0, 0);
    s_flush   = mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    s_flush_v = mk_stim(1, 1, 12, 13, 14, 15, 6, 7, 32'h55, 32'h66, 0, 1);

    vecs[0].s = s_dual;
    vecs[0].e = mk_ret(1, 1, 1, 1, 1, 2, 32, 33, 1, 2, 32'hAABBCCDD, 32'h11223344);
    vecs[1].s = mk_stim(1, 1, 10, 11, 3, 4, 5, 5, 32'h1, 32'h2, 0, 0);
    vecs[1].e = mk_ret(1, 1, 0, 1, 3, 4, 10, 11, 5, 5, 32'h1, 32'h2);
    vecs[2].s = mk_stim(1, 0, 40, 0, 7, 0, 0, 0, 32'h55, 0, 0, 0);
    vecs[2].e = mk_ret(1, 0, 0, 0, 7, 0, 40, 0, 0, 0, 32'h55, 0);
    vecs[3].s = mk_stim(1, 1, 21, 22, 23, 24, 3, 4, 32'h77, 32'h88, 1, 0);
    vecs[3].e = '0;
    vecs[4].s = mk_stim(0, 1, 21, 22, 23, 24, 3, 4, 32'h77, 32'h88, 0, 0);
    vecs[4].e = '0;
    vecs[5].s = mk_stim(1, 1, 50, 51, 60, 61, 3, 0, 32'hDEAD, 32'hBEEF, 0, 0);
    vecs[5].e = mk_ret(1, 1, 1, 0, 60, 61, 50, 51, 3, 0, 32'hDEAD, 32'hBEEF);
    vecs[6].s = mk_stim(1, 1, 8, 9, 10, 11, 0, 0, 32'h5, 32'h6, 0, 0);
    vecs[6].e = mk_ret(1, 1, 0, 0, 10, 11, 8, 9, 0, 0, 32'h5, 32'h6);

    do_reset();
    // IDLE cycle right after reset: valid present but not accepted.
    run_cycle(s_valid, 0);

    for (int i = 0; i < 7; i++) begin
      run_cycle(vecs[i].s, -1);
      check_ret($sformatf("vec%0d", i), vecs[i].e);
      run_cycle(s_idle, -1);
      check_ret($sformatf("vec%0d_after", i), '0);
    end

    // Commit at N, flush at N+1: retire still emitted, blackout N+1..N+3.
    run_cycle(s_dual, 1);
    check("flush_retire_kept", 64'(bus.retire_valid1), 64'(1));
    run_cycle(s_flush_v, 0);
    check("flush_cycle_no_accept", 64'(bus.retire_valid1), 64'(0));
    run_cycle(s_valid, 0);
    run_cycle(s_valid, 0);
    run_cycle(s_valid, 1);
    run_cycle(s_idle, -1);

    // Flush re-asserted inside the blackout restarts the countdown.
    run_cycle(s_flush, 0);
    run_cycle(s_idle, 0);
    run_cycle(s_flush, 0);
    run_cycle(s_idle, 0);
    run_cycle(s_idle, 0);
    run_cycle(s_valid, 1);
    run_cycle(s_idle, -1);

    // Counter: 3 dual + 1 single from reset; flush does not clear it.
    do_reset();
    run_cycle(s_idle, 0);
    for (int i = 0; i < 3; i++) run_cycle(s_dual, 1);
    run_cycle(s_single, 1);
`ifdef COMMIT_PERF_EN
    check("count_seven", 64'(bus.commit_count), 64'(7));
`else
    check("count_tied_zero", 64'(bus.commit_count), 64'(0));
`endif
    run_cycle(s_flush, 0);
    run_cycle(s_idle, 0);
    run_cycle(s_idle, 0);
`ifdef COMMIT_PERF_EN
    check("count_after_flush", 64'(bus.commit_count), 64'(7));
`endif

    // Reset while a retire is registered: it must not appear.
    apply(s_dual);
    #1;
    check("midreset_ready", 64'(bus.rob_commit_ready), 64'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge clk);
    do_reset();
    run_cycle(s_idle, 0);
    check_ret("midreset_dropped", '0);

    // Randomized traffic against the model.
    do_reset();
    run_cycle(s_idle, 0);
    for (int i = 0; i < 400; i++) begin
      stim_t s;
      s.v1    = ($urandom_range(0, 3) != 0);
      s.v2    = ($urandom_range(0, 2) != 0);
      s.dest1 = PW'($urandom_range(0, 63));
      s.dest2 = PW'($urandom_range(0, 63));
      s.old1  = PW'($urandom_range(0, 63));
      s.old2  = PW'($urandom_range(0, 63));
      s.arch1 = AW'($urandom_range(0, 3));
      s.arch2 = AW'($urandom_range(0, 3));
      s.val1  = $urandom;
      s.val2  = $urandom;
      s.hold  = ($urandom_range(0, 4) == 0);
      s.flush = ($urandom_range(0, 15) == 0);
      run_cycle(s, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/commit_scheduler.md
COMMIT_SCHEDULER -- requirements
Module: commit_scheduler

Interface
REQ-001 SHALL have parameters: PREG_W, default 6, physical register index width; AREG_W, default 5, architectural register index width; DATA_W, default 32, data width; FLUSH_CYCLES, default 2, commit blackout length after flush.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  pipeline flush request.
- hold  in  1  downstream backpressure (free list / regfile busy).
- rob_commit_valid_1/_2  in  1  ROB head / head+1 ready to commit.
- rob_commit_dest_1/_2  in  PREG_W  new physical rd.
- rob_free_oldDest_1/_2  in  PREG_W  previous physical rd mapping.
- rob_commit_arch_1/_2  in  AREG_W  architectural rd.
- rob_commit_value_1/_2  in  DATA_W  result.
- rob_commit_ready  out  1  commit accept to ROB.
- retire_valid1/2  out  1  free-list release strobes to rename.
- retire_phys_reg1/2  out  PREG_W  physical reg to free (old mapping).
- retire_cur_phys_reg1/2  out  PREG_W  committed physical reg.
- RegWrite1/2  out  1  architectural regfile write enables.
- rd1/rd2  out  AREG_W  regfile write addresses.
- rd1_data/rd2_data  out  DATA_W  regfile write data.
- commit_count  out  32  retired-instruction count.
- busy  out  1  high when state != RUN or a retire is in flight.

Function
REQ-003 SHALL implement FSM states IDLE, RUN, FLUSH.
REQ-004 SHALL transition IDLE->RUN on the first cycle after reset deasserts.
REQ-005 SHALL transition RUN->FLUSH when flush=1, load a blackout counter with FLUSH_CYCLES, and return FLUSH->RUN when the counter reaches 0.
REQ-006 SHALL restart the counter at FLUSH_CYCLES when flush is re-asserted while in FLUSH.
REQ-007 SHALL drive rob_commit_ready = (state==RUN) & ~hold & ~flush, combinationally.
REQ-008 SHALL treat slot 1 as accepted when rob_commit_valid_1 & rob_commit_ready.
REQ-009 SHALL treat slot 2 as accepted only when slot 1 is accepted and rob_commit_valid_2=1; valid_2 without valid_1 is ignored.
REQ-010 SHALL register accepted slots and present all retire and regfile outputs exactly 1 cycle after acceptance, for exactly 1 cycle.
REQ-011 SHALL drive all retire and regfile outputs to 0 in cycles with no accepted slot.
REQ-012 SHALL assert retire_validN for every accepted slot, including writes to arch reg 0.
REQ-013 SHALL suppress RegWriteN when rob_commit_arch_N == 0.
REQ-014 SHALL, when both slots are accepted with equal nonzero arch rd, suppress RegWrite1 and assert RegWrite2 (younger wins); both retire_valid strobes still fire.
REQ-015 SHALL complete, not cancel, a retire already registered when flush arrives.
REQ-016 SHALL accept no new commit in the flush cycle itself.
REQ-017 SHALL let hold block acceptance only; registered outputs still emit.

Reset
REQ-018 SHALL, while reset=1, force state to IDLE, rob_commit_ready to 0, all retire, RegWrite, rd, data and busy outputs to 0, commit_count to 0, and clear the blackout counter.
REQ-019 SHALL, on reset asserted mid-operation, drop any in-flight registered retire.

Configuration
REQ-020 SHALL count, with COMMIT_PERF_EN defined, accepted slots into commit_count (+1 or +2 per cycle, wrapping mod 2^32, cleared by reset, not cleared by flush).
REQ-021 SHALL, without COMMIT_PERF_EN, keep the commit_count port present and tie it to 0.

Structure
REQ-022 SHALL take PREG_W/AREG_W/DATA_W defaults and the state enum type from shared package ooo_pkg, so rename, reorder_buffer and reg_file use the same widths.
REQ-023 SHALL place the counter in sub-module commit_perf_ctr, instantiated only under COMMIT_PERF_EN; all else stays in one module.

Verification
REQ-024 SHALL pass dual commit: valid_1=valid_2=1, dest 32/33, oldDest 1/2, arch 1/2, values AABBCCDD/11223344 -> next cycle retire_valid1/2=1, retire_phys_reg1/2=1/2, retire_cur_phys_reg1/2=32/33, RegWrite1/2=1, rd1/rd2=1/2, data matches; all zero the cycle after.
REQ-025 SHALL pass same-rd pair: both slots arch 5 -> RegWrite1=0, RegWrite2=1, rd2=5, retire_valid1/2=1.
REQ-026 SHALL pass arch 0: slot 1 arch 0, dest 40 -> RegWrite1=0, retire_valid1=1, retire_cur_phys_reg1=40.
REQ-027 SHALL pass flush: commit accepted in cycle N, flush in N+1 -> retire outputs at N+1 still emitted; rob_commit_ready=0 for cycles N+1..N+3 (FLUSH_CYCLES=2); ready=1 at N+4 with hold=0.
REQ-028 SHALL pass hold and ordering: hold=1 with valid_1=1 -> ready=0, no retire; valid_2 alone -> no retire.
REQ-029 SHALL pass counter checks (COMMIT_PERF_EN): 3 dual plus 1 single commit -> commit_count=7; reset mid-stream -> 0 and in-flight retire dropped.
